// File: rtl/gx4000_asic_unlock_snoop_pkg.sv
// Shared constants for the GX4000/Plus ASIC block: unlock sequence and CRTC port decode.
package gx4000_pkg;

    localparam int unsigned SEQ_LEN = 17;

    typedef logic [4:0] seq_idx_t;

    localparam seq_idx_t UNLOCK_KEY_IDX = 5'd16;
    localparam logic [7:0] UNLOCK_BYTE = 8'hEE;

    // Index 0 is the least significant byte: FF 00 FF 77 B3 51 A8 D4 62 39 9C 46 2B 15 8A CD EE.
    localparam logic [SEQ_LEN-1:0][7:0] UNLOCK_SEQ = {
        8'hEE, 8'hCD, 8'h8A, 8'h15, 8'h2B, 8'h46, 8'h9C, 8'h39, 8'h62,
        8'hD4, 8'hA8, 8'h51, 8'hB3, 8'h77, 8'hFF, 8'h00, 8'hFF
    };

    // CRTC register-select port: A14=0, A9=0, A8=0 (e.g. &BC00).
    localparam logic [15:0] CRTC_SEL_MASK  = 16'h4300;
    localparam logic [15:0] CRTC_SEL_MATCH = 16'h0000;

    function automatic logic port_hit(input logic [15:0] addr, input logic [15:0] mask,
                                      input logic [15:0] match);
        return (addr & mask) == match;
    endfunction

endpackage

// File: rtl/gx4000_asic_unlock_snoop_if.sv
// Z80 I/O write bus as seen by the ASIC snoop logic.
interface gx4000_asic_unlock_snoop_if;
    logic [15:0] io_addr;
    logic [7:0]  io_data;
    logic        io_wr;

    modport master (output io_addr, output io_data, output io_wr);
    modport slave  (input io_addr, input io_data, input io_wr);
endinterface

// File: rtl/gx4000_asic_unlock_snoop.sv
// Snoops CRTC select-port writes, matches the 17-byte ASIC unlock sequence and tracks the lock.
module gx4000_asic_unlock_snoop
    import gx4000_pkg::*;
#(
    parameter logic [15:0] SEL_MASK      = CRTC_SEL_MASK,
    parameter logic [15:0] SEL_MATCH     = CRTC_SEL_MATCH,
    parameter bit          LOCK_ON_RESET = 1'b1
) (
    input  logic                         clk_sys,
    input  logic                         reset,
    input  logic                         plus_enable,
    input  logic                         force_unlock,
    gx4000_asic_unlock_snoop_if.slave    io,
    output logic                         asic_locked,
    output logic                         unlock_pulse,
    output logic                         lock_pulse,
    output seq_idx_t                     seq_index
);

    logic     io_wr_q;
    seq_idx_t seq_q, seq_d;
    logic     locked_q, locked_d;
    logic     unlock_pulse_q, unlock_pulse_d;
    logic     lock_pulse_q, lock_pulse_d;
    logic     sel_hit;
    logic     wr_event;

    assign sel_hit  = port_hit(io.io_addr, SEL_MASK, SEL_MATCH);
    assign wr_event = io.io_wr & ~io_wr_q & plus_enable & sel_hit;

    always_comb begin
        seq_d    = seq_q;
        locked_d = locked_q;

        if (wr_event) begin
            if (seq_q == UNLOCK_KEY_IDX) begin
                // Final byte: EE unlocks, anything else deliberately relocks.
                seq_d    = '0;
                locked_d = (io.io_data != UNLOCK_BYTE);
            end else if (io.io_data == UNLOCK_SEQ[seq_q]) begin
                seq_d = seq_q + 5'd1;
            end else if (io.io_data == UNLOCK_SEQ[0]) begin
                seq_d = 5'd1;
            end else begin
                seq_d = '0;
            end
        end

        if (force_unlock) begin
            locked_d = 1'b0;
        end

        if (!plus_enable) begin
            seq_d    = '0;
            locked_d = LOCK_ON_RESET;
        end

        unlock_pulse_d = plus_enable & locked_q & ~locked_d;
        lock_pulse_d   = plus_enable & ~locked_q & locked_d;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            io_wr_q        <= 1'b0;
            seq_q          <= '0;
            locked_q       <= LOCK_ON_RESET;
            unlock_pulse_q <= 1'b0;
            lock_pulse_q   <= 1'b0;
        end else begin
            io_wr_q        <= io.io_wr;
            seq_q          <= seq_d;
            locked_q       <= locked_d;
            unlock_pulse_q <= unlock_pulse_d;
            lock_pulse_q   <= lock_pulse_d;
        end
    end

    assign asic_locked  = locked_q;
    assign unlock_pulse = unlock_pulse_q;
    assign lock_pulse   = lock_pulse_q;
    assign seq_index    = seq_q;

endmodule

// File: tb/tb_gx4000_asic_unlock_snoop.sv
// Directed vector bench for the ASIC unlock snoop: table of write transactions plus corner sequences.
module tb_gx4000_asic_unlock_snoop;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        int          hold;
        int          exp_idx;
        int          exp_locked;
        int          exp_up;
        int          exp_lp;
    } vec_t;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic       plus_enable;
    logic       force_unlock;
    logic       asic_locked;
    logic       unlock_pulse;
    logic       lock_pulse;
    logic [4:0] seq_index;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] seq [17] = '{8'hFF, 8'h00, 8'hFF, 8'h77, 8'hB3, 8'h51, 8'hA8, 8'hD4, 8'h62,
                             8'h39, 8'h9C, 8'h46, 8'h2B, 8'h15, 8'h8A, 8'hCD, 8'hEE};
    vec_t vecs[$];

    localparam logic [15:0] SEL  = 16'hBC00;
    localparam logic [15:0] DATA = 16'hBD00;

    gx4000_asic_unlock_snoop_if bus ();

    gx4000_asic_unlock_snoop dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .plus_enable  (plus_enable),
        .force_unlock (force_unlock),
        .io           (bus),
        .asic_locked  (asic_locked),
        .unlock_pulse (unlock_pulse),
        .lock_pulse   (lock_pulse),
        .seq_index    (seq_index)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [15:0] addr, input logic [7:0] data, input int hold,
                       input int idx, input int locked, input int up, input int lp);
        vec_t v;
        v.addr = addr; v.data = data; v.hold = hold;
        v.exp_idx = idx; v.exp_locked = locked; v.exp_up = up; v.exp_lp = lp;
        vecs.push_back(v);
    endtask

    // One strobe held for 'hold' cycles then one idle cycle; counts pulses seen throughout.
    task automatic do_write(input logic [15:0] addr, input logic [7:0] data, input int hold,
                            output int up, output int lp);
        up = 0; lp = 0;
        bus.io_addr = addr;
        bus.io_data = data;
        bus.io_wr   = 1'b1;
        for (int c = 0; c < hold; c++) begin
            @(posedge clk_sys); #1;
            up += int'(unlock_pulse);
            lp += int'(lock_pulse);
        end
        bus.io_wr = 1'b0;
        @(posedge clk_sys); #1;
        up += int'(unlock_pulse);
        lp += int'(lock_pulse);
    endtask

    task automatic step(input int cycles, output int up, output int lp);
        up = 0; lp = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk_sys); #1;
            up += int'(unlock_pulse);
            lp += int'(lock_pulse);
        end
    endtask

    initial begin
        int up, lp;

        // 1: full sequence unlocks, one unlock pulse on the EE write
        for (int i = 0; i < 16; i++) add(SEL, seq[i], 2, i + 1, 1, 0, 0);
        add(SEL, 8'hEE, 2, 0, 0, 1, 0);
        // 2: 16 bytes then a non-EE final byte relocks
        for (int i = 0; i < 16; i++) add(SEL, seq[i], 2, i + 1, 0, 0, 0);
        add(SEL, 8'hA5, 2, 0, 1, 0, 1);
        // 3: stray FF at index 5 resynchronises to index 1
        for (int i = 0; i < 5; i++) add(SEL, seq[i], 1, i + 1, 1, 0, 0);
        for (int i = 0; i < 16; i++) add(SEL, seq[i], 1, i + 1, 1, 0, 0);
        add(SEL, 8'hEE, 1, 0, 0, 1, 0);
        // relock, then 4: data-port writes inside a sequence are ignored
        for (int i = 0; i < 16; i++) add(SEL, seq[i], 1, i + 1, 0, 0, 0);
        add(SEL, 8'h12, 1, 0, 1, 0, 1);
        for (int i = 0; i < 16; i++) begin
            add(SEL, seq[i], 1, i + 1, 1, 0, 0);
            if (i == 5)  add(DATA, 8'h00, 1, 6, 1, 0, 0);
            if (i == 10) add(DATA, 8'hEE, 1, 11, 1, 0, 0);
        end
        add(SEL, 8'hEE, 1, 0, 0, 1, 0);
        // 5: FF held for 6 cycles advances only once; then walk to index 9
        add(SEL, 8'hFF, 6, 1, 0, 0, 0);
        for (int i = 1; i < 9; i++) add(SEL, seq[i], 2, i + 1, 0, 0, 0);

        reset = 1'b1; plus_enable = 1'b1; force_unlock = 1'b0;
        bus.io_addr = '0; bus.io_data = '0; bus.io_wr = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
        chk("reset_locked", int'(asic_locked), 1);
        chk("reset_idx", int'(seq_index), 0);
        chk("reset_up", int'(unlock_pulse), 0);
        chk("reset_lp", int'(lock_pulse), 0);
        reset = 1'b0;
        @(posedge clk_sys); #1;

        foreach (vecs[n]) begin
            do_write(vecs[n].addr, vecs[n].data, vecs[n].hold, up, lp);
            chk($sformatf("v%0d_idx", n), int'(seq_index), vecs[n].exp_idx);
            chk($sformatf("v%0d_locked", n), int'(asic_locked), vecs[n].exp_locked);
            chk($sformatf("v%0d_up", n), up, vecs[n].exp_up);
            chk($sformatf("v%0d_lp", n), lp, vecs[n].exp_lp);
        end

        // reset at index 9 coinciding with a select write: reset wins
        bus.io_addr = SEL; bus.io_data = 8'h39; bus.io_wr = 1'b1; reset = 1'b1;
        @(posedge clk_sys); #1;
        chk("rst_mid_idx", int'(seq_index), 0);
        chk("rst_mid_locked", int'(asic_locked), 1);
        reset = 1'b0; bus.io_wr = 1'b0;
        step(1, up, lp);
        chk("rst_after_idx", int'(seq_index), 0);

        // 6: force_unlock held 3 cycles from locked
        force_unlock = 1'b1;
        step(3, up, lp);
        chk("force_locked", int'(asic_locked), 0);
        chk("force_up", up, 1);
        force_unlock = 1'b0;
        step(2, up, lp);
        chk("force_rel_locked", int'(asic_locked), 0);
        chk("force_rel_pulses", up + lp, 0);

        // plus_enable low: lock restored silently, writes ignored
        plus_enable = 1'b0;
        step(1, up, lp);
        chk("dis_locked", int'(asic_locked), 1);
        chk("dis_lp", lp, 0);
        do_write(SEL, 8'hFF, 1, up, lp);
        do_write(SEL, 8'h00, 1, up, lp);
        chk("dis_idx", int'(seq_index), 0);
        plus_enable = 1'b1;
        step(1, up, lp);
        chk("en_locked", int'(asic_locked), 1);
        chk("en_pulses", up + lp, 0);

        // force_unlock beats a relocking final byte
        do_write(SEL, 8'h00, 1, up, lp);
        chk("en_first_idx", int'(seq_index), 0);
        for (int i = 0; i < 16; i++) do_write(SEL, seq[i], 1, up, lp);
        chk("pre_key_idx", int'(seq_index), 16);
        force_unlock = 1'b1;
        do_write(SEL, 8'h00, 1, up, lp);
        chk("force_key_locked", int'(asic_locked), 0);
        chk("force_key_idx", int'(seq_index), 0);
        chk("force_key_up", up, 1);
        chk("force_key_lp", lp, 0);
        force_unlock = 1'b0;
        step(1, up, lp);
        chk("force_key_after", int'(asic_locked), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gx4000_asic_unlock_snoop.md
Name: gx4000_asic_unlock_snoop

Overview:
Upstream stage of the GX4000/Plus ASIC register block.
- Snoops Z80 I/O writes to the CRTC register-select port and runs the 17-byte ASIC unlock sequence matcher.
- Produces the lock state, lock/unlock event pulses and a matcher debug index.
- The ASIC register decoder consumes asic_locked to gate access to the &4000-&7FFF register page and the status byte.

Parameters:
SEL_MASK, 16'h4300, address bits compared for CRTC select-port decode (A14, A9, A8)
SEL_MATCH, 16'h0000, required value of (io_addr & SEL_MASK) for a select-port write
LOCK_ON_RESET, 1, value asic_locked takes on reset

Ports:
clk_sys  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
plus_enable  in  1  Plus/GX4000 mode; when 0, snooping is disabled and the lock is held
force_unlock  in  1  level; unlocks while high
io_addr  in  16  CPU I/O address
io_data  in  8  CPU write data
io_wr  in  1  CPU I/O write strobe, level, may stay high for several cycles
asic_locked  out  1  1 = ASIC registers hidden
unlock_pulse  out  1  one-cycle pulse on a locked->unlocked transition
lock_pulse  out  1  one-cycle pulse on an unlocked->locked transition
seq_index  out  5  matcher position 0..16 (debug/verification)

Behaviour:
- Reset values:
  - asic_locked = LOCK_ON_RESET
  - seq_index = 0
  - unlock_pulse = 0, lock_pulse = 0
  - internal io_wr_q = 0
- Write event: io_wr & ~io_wr_q & plus_enable & ((io_addr & SEL_MASK) == SEL_MATCH).
  - Fires exactly once per strobe, however long io_wr is held.
  - io_data is sampled in the event cycle.
- Event effects become visible on the registered outputs on the next rising edge (latency 1).
- Sequence UNLOCK_SEQ[0..16]: FF 00 FF 77 B3 51 A8 D4 62 39 9C 46 2B 15 8A CD EE.
- Matcher, on each event with index k and byte d:
  - k<16, d==UNLOCK_SEQ[k]: k <= k+1.
  - k<16, mismatch, d==FF: k <= 1 (resynchronise on a new leading FF).
  - k<16, mismatch, any other d: k <= 0.
  - k==16, d==EE: asic_locked <= 0, k <= 0.
  - k==16, any other d: asic_locked <= 1, k <= 0. This is the deliberate relock path.
- Transition pulses:
  - unlock_pulse fires only when asic_locked changes 1->0.
  - lock_pulse fires only when asic_locked changes 0->1.
  - Re-unlocking an unlocked ASIC produces no pulse; likewise re-locking a locked one.
- force_unlock high:
  - asic_locked <= 0 every cycle, with unlock_pulse on the 1->0 transition only.
  - The matcher keeps running, but a k==16 non-EE byte cannot lock while force_unlock is high.
- plus_enable low:
  - No events are generated.
  - seq_index <= 0.
  - asic_locked <= LOCK_ON_RESET.
  - No pulses.
- Writes to other ports (CRTC data port A8=1, gate array, PPI) and all reads are ignored; the matcher state is preserved.
- Simultaneous events:
  - A reset asserted in the same cycle as an event: reset wins.
  - force_unlock in the same cycle as a relocking event: force_unlock wins.
- Reset mid-sequence returns seq_index to 0; a partially entered sequence must then be restarted.
- Width rule: seq_index never exceeds 16; wrap to 0 is explicit, never by arithmetic overflow.

Decomposition:
- Package gx4000_pkg holds:
  - UNLOCK_SEQ (17 x 8-bit constant array)
  - SEQ_LEN = 17
  - UNLOCK_KEY_IDX = 16
  - UNLOCK_BYTE = 8'hEE
- Same package types: the CRTC port decode constants, which the ASIC block also needs.
- No sub-module. The edge detector and the 5-bit matcher are a single always block plus decode; target roughly 150 lines.

Test Plan:
1. Reset, plus_enable=1, write all 17 bytes to &BC00 (io_wr held 2 cycles each) -> seq_index steps 1..16, asic_locked 1->0 one cycle after the EE event, unlock_pulse high exactly 1 cycle.
2. Unlocked; send FF 00 … CD then A5 -> asic_locked 0->1, lock_pulse 1 cycle, seq_index 0.
3. Send FF 00 FF 77 B3 then FF 00 FF 77 … EE -> seq_index drops to 1 at the mismatching FF, the full sequence still unlocks.
4. Interleave &BD00 data-port writes (values 00, EE) inside a valid sequence -> ignored, seq_index unchanged by them, unlock still occurs.
5. Hold io_wr high 6 cycles with data FF at index 0 -> seq_index = 1 (not 2+); reset asserted at index 9 -> seq_index 0, asic_locked 1.
6. force_unlock pulse 3 cycles from locked -> asic_locked 0, single unlock_pulse; plus_enable=0 then 1 -> asic_locked 1, no lock_pulse, sequence writes ignored while disabled.
